// File: rtl/i2c_pkg.sv
// Shared I2C definitions: command codes, bit polarities, controller states and the
// on-board slave address.
package i2c_pkg;

  typedef enum logic [1:0] {
    I2C_START = 2'd0,
    I2C_WRITE = 2'd1,
    I2C_READ  = 2'd2,
    I2C_STOP  = 2'd3
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_HOLD,
    ST_WRITE,
    ST_READ,
    ST_STOP
  } state_t;

  localparam logic       ACK      = 1'b0;
  localparam logic       NACK     = 1'b1;
  localparam logic [6:0] SLV_ADDR = 7'b1010_000;
  localparam logic [3:0] BIT_ACK  = 4'd8;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period strobe for the I2C master: one-cycle tick every CLK_DIV clocks
// while enabled; the count restarts from zero whenever enable drops.
module i2c_tick_gen #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_reg;
  logic          tick_reg;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      count_reg <= '0;
      tick_reg  <= 1'b0;
    end else begin
      tick_reg  <= (count_reg == LAST);
      count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/i2c_master.sv
// Byte-level single-master I2C controller: executes START / WRITE / READ / STOP
// one at a time, each bit split into four registered quarter phases.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  input  logic [7:0] tx_data,
  input  logic       rd_nack,
  output logic [7:0] rx_data,
  output logic       ack_err,
  output logic       done,
  output logic       busy,
  inout  wire        SDA,
  output logic       SCL
);

  state_t     state_reg, state_next;
  logic [1:0] qtr_reg, qtr_next;
  logic [3:0] bit_reg, bit_next;
  logic [7:0] tx_reg, tx_next;
  logic       nack_reg, nack_next;
  logic [7:0] rx_shift_reg, rx_shift_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       ack_err_reg, ack_err_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic       scl_reg, scl_next;
  logic       sda_low_reg, sda_low_next;
  logic       cmd_ready_reg;
  logic       sda_meta_reg, sda_sync_reg;
  logic       accept;
  logic       tick;
  logic       tick_enable;
  cmd_t       cmd_code;

  assign cmd_code    = cmd_t'(cmd);
  assign tick_enable = (state_reg != ST_IDLE) && (state_reg != ST_HOLD);

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (tick_enable),
    .tick   (tick)
  );

  always_comb begin
    state_next    = state_reg;
    qtr_next      = qtr_reg;
    bit_next      = bit_reg;
    tx_next       = tx_reg;
    nack_next     = nack_reg;
    rx_shift_next = rx_shift_reg;
    rx_data_next  = rx_data_reg;
    ack_err_next  = ack_err_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    accept        = cmd_valid && cmd_ready_reg;

    if (accept) begin
      // Only START is meaningful without owning the bus; anything else is dropped.
      if (state_reg == ST_HOLD || cmd_code == I2C_START) begin
        qtr_next = 2'd0;
        bit_next = 4'd0;
        case (cmd_code)
          I2C_START: state_next = ST_START;
          I2C_WRITE: begin
            state_next = ST_WRITE;
            tx_next    = tx_data;
          end
          I2C_READ: begin
            state_next = ST_READ;
            nack_next  = rd_nack;
          end
          default:   state_next = ST_STOP;
        endcase
      end
    end else if (tick) begin
      if (qtr_reg == 2'd1) begin
        if (state_reg == ST_WRITE && bit_reg == BIT_ACK) begin
          ack_err_next = (sda_sync_reg == NACK);
        end else if (state_reg == ST_READ && bit_reg < BIT_ACK) begin
          rx_shift_next = {rx_shift_reg[6:0], sda_sync_reg};
          if (bit_reg == 4'd7) begin
            rx_data_next = {rx_shift_reg[6:0], sda_sync_reg};
          end
        end
      end
      if (qtr_reg != 2'd3) begin
        qtr_next = qtr_reg + 2'd1;
      end else begin
        qtr_next = 2'd0;
        case (state_reg)
          ST_START: begin
            state_next = ST_HOLD;
            busy_next  = 1'b1;
            done_next  = 1'b1;
          end
          ST_WRITE, ST_READ: begin
            if (bit_reg == BIT_ACK) begin
              state_next = ST_HOLD;
              done_next  = 1'b1;
            end else begin
              bit_next = bit_reg + 4'd1;
            end
          end
          ST_STOP: begin
            state_next = ST_IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end
          default: ;
        endcase
      end
    end

    // Bus levels are decoded from the phase being entered so they change on the same edge.
    scl_next     = scl_reg;
    sda_low_next = sda_low_reg;
    case (state_next)
      ST_IDLE: begin
        scl_next     = 1'b1;
        sda_low_next = 1'b0;
      end
      ST_HOLD:  scl_next = 1'b0;
      ST_START: begin
        case (qtr_next)
          2'd0: sda_low_next = 1'b0;
          2'd1: begin scl_next = 1'b1; sda_low_next = 1'b0; end
          2'd2: begin scl_next = 1'b1; sda_low_next = 1'b1; end
          default: begin scl_next = 1'b0; sda_low_next = 1'b1; end
        endcase
      end
      ST_WRITE: begin
        scl_next     = (qtr_next == 2'd1) || (qtr_next == 2'd2);
        sda_low_next = (bit_next < BIT_ACK) ? ~tx_next[~bit_next[2:0]] : 1'b0;
      end
      ST_READ: begin
        scl_next     = (qtr_next == 2'd1) || (qtr_next == 2'd2);
        sda_low_next = (bit_next == BIT_ACK) && (nack_next == ACK);
      end
      ST_STOP: begin
        scl_next     = (qtr_next != 2'd0);
        sda_low_next = (qtr_next < 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      qtr_reg       <= 2'd0;
      bit_reg       <= 4'd0;
      tx_reg        <= 8'h00;
      nack_reg      <= 1'b0;
      rx_shift_reg  <= 8'h00;
      rx_data_reg   <= 8'h00;
      ack_err_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      scl_reg       <= 1'b1;
      sda_low_reg   <= 1'b0;
      cmd_ready_reg <= 1'b1;
      sda_meta_reg  <= 1'b1;
      sda_sync_reg  <= 1'b1;
    end else begin
      state_reg     <= state_next;
      qtr_reg       <= qtr_next;
      bit_reg       <= bit_next;
      tx_reg        <= tx_next;
      nack_reg      <= nack_next;
      rx_shift_reg  <= rx_shift_next;
      rx_data_reg   <= rx_data_next;
      ack_err_reg   <= ack_err_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      scl_reg       <= scl_next;
      sda_low_reg   <= sda_low_next;
      cmd_ready_reg <= (state_next == ST_IDLE) || (state_next == ST_HOLD);
      sda_meta_reg  <= SDA;
      sda_sync_reg  <= sda_meta_reg;
    end
  end

  assign SDA       = sda_low_reg ? 1'b0 : 1'bz;
  assign SCL       = scl_reg;
  assign cmd_ready = cmd_ready_reg;
  assign rx_data   = rx_data_reg;
  assign ack_err   = ack_err_reg;
  assign done      = done_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: table of commands with hand-computed results against a
// small behavioural I2C slave (address 0x50, returns 0xC3), plus a mid-write reset.
module tb_i2c_master;
  import i2c_pkg::*;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic [7:0] tx_data;
  logic       rd_nack;
  logic [7:0] rx_data;
  logic       ack_err;
  logic       done;
  logic       busy;
  wire        sda_bus;
  logic       scl;

  int checks = 0;
  int errors = 0;

  i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .tx_data   (tx_data),
    .rd_nack   (rd_nack),
    .rx_data   (rx_data),
    .ack_err   (ack_err),
    .done      (done),
    .busy      (busy),
    .SDA       (sda_bus),
    .SCL       (scl)
  );

  always #5 clk = ~clk;

  // Bus pull-up and slave open-drain driver
  pullup (sda_bus);
  logic s_low = 1'b0;
  assign sda_bus = s_low ? 1'b0 : 1'bz;

  logic       scl_p = 1'b1, sda_p = 1'b1;
  logic       s_active = 1'b0, s_addr_ph = 1'b0, s_rd = 1'b0, s_hit = 1'b0, s_macked = 1'b0;
  logic       sda_at_rise = 1'b0;
  logic [3:0] s_bit = 4'd0;
  logic [7:0] s_sh = 8'h00, s_tx = 8'h00, slv_recv = 8'h00;
  logic [7:0] slv_send = 8'hC3;
  int         scl_rises = 0, hi_chg = 0, slv_starts = 0;

  // Slave model and bus monitor, oversampling SCL/SDA on the system clock
  always @(posedge clk) begin
    scl_p <= scl;
    sda_p <= sda_bus;
    if (scl && !scl_p) begin
      scl_rises   <= scl_rises + 1;
      sda_at_rise <= sda_bus;
    end
    if (scl && scl_p && (sda_bus != sda_p)) hi_chg <= hi_chg + 1;
    if (scl && scl_p && sda_p && !sda_bus) begin
      s_active   <= 1'b1;
      s_addr_ph  <= 1'b1;
      s_bit      <= 4'd0;
      s_low      <= 1'b0;
      slv_starts <= slv_starts + 1;
    end else if (scl && scl_p && !sda_p && sda_bus) begin
      s_active <= 1'b0;
      s_low    <= 1'b0;
    end else if (s_active && scl && !scl_p) begin
      if (s_bit < 4'd8) s_sh <= {s_sh[6:0], sda_bus};
      else s_macked <= !sda_bus;
      s_bit <= s_bit + 4'd1;
    end else if (s_active && !scl && scl_p) begin
      if (s_bit >= 4'd1 && s_bit <= 4'd7) begin
        if (s_rd && !s_addr_ph) begin
          s_low <= !s_tx[6];
          s_tx  <= {s_tx[6:0], 1'b0};
        end
      end else if (s_bit == 4'd8) begin
        if (s_addr_ph) begin
          s_rd  <= s_sh[0];
          s_hit <= (s_sh[7:1] == SLV_ADDR);
          s_low <= (s_sh[7:1] == SLV_ADDR);
        end else if (!s_rd) begin
          slv_recv <= s_sh;
          s_low    <= 1'b1;
        end else begin
          s_low <= 1'b0;
        end
      end else if (s_bit == 4'd9) begin
        s_bit     <= 4'd0;
        s_addr_ph <= 1'b0;
        if (!s_hit) begin
          s_active <= 1'b0;
          s_low    <= 1'b0;
        end else if (s_rd && (s_addr_ph || s_macked)) begin
          s_tx  <= slv_send;
          s_low <= !slv_send[7];
        end else begin
          s_low <= 1'b0;
          if (s_rd) s_active <= 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [1:0] c;
    logic [7:0] d;
    logic       n;
    int         lat;
    int         rises;
    int         hichg;
    int         starts;
    logic       ack;
    logic [7:0] rx;
    logic       bsy;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic [1:0] c, input logic [7:0] d, input logic n,
                              input int lat, input int rises, input int hichg, input int starts,
                              input logic ack, input logic [7:0] rx, input logic bsy);
    vec_t v;
    v.c = c; v.d = d; v.n = n; v.lat = lat; v.rises = rises; v.hichg = hichg;
    v.starts = starts; v.ack = ack; v.rx = rx; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    int k, r0, h0, s0, lat;
    @(posedge clk); #1;
    chk({tag, " ready_before"}, cmd_ready, 1);
    r0 = scl_rises; h0 = hi_chg; s0 = slv_starts;
    cmd_valid = 1'b1; cmd = v.c; tx_data = v.d; rd_nack = v.n;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    k = 0;
    while (!done && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    lat = done ? k : -1;
    @(posedge clk); #1;
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " scl_rises"}, scl_rises - r0, v.rises);
    chk({tag, " sda_chg_scl_high"}, hi_chg - h0, v.hichg);
    chk({tag, " start_conds"}, slv_starts - s0, v.starts);
    chk({tag, " done_pulse_low"}, done, 0);
    chk({tag, " ack_err"}, ack_err, v.ack);
    chk({tag, " rx_data"}, rx_data, v.rx);
    chk({tag, " busy"}, busy, v.bsy);
    chk({tag, " scl_level"}, scl, !v.bsy);
    chk({tag, " cmd_ready"}, cmd_ready, 1);
    if (!v.bsy) chk({tag, " sda_idle"}, sda_bus, 1);
    if (v.c == I2C_READ && v.lat > 0) chk({tag, " sda_read_bit8"}, sda_at_rise, v.n);
    $display("cmd %s c=%0d d=%02h lat=%0d ack_err=%0b rx=%02h busy=%0b", tag, v.c, v.d, lat, ack_err, rx_data, busy);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd = 2'd0; tx_data = 8'h00; rd_nack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst scl", scl, 1);
    chk("rst sda", sda_bus, 1);
    chk("rst cmd_ready", cmd_ready, 1);
    chk("rst done", done, 0);
    chk("rst busy", busy, 0);
    chk("rst ack_err", ack_err, 0);
    chk("rst rx_data", rx_data, 8'h00);
    reset = 1'b0;

    //            cmd        data   n     lat rise hi st ack   rx     busy
    vecs[0]  = mk(I2C_START, 8'h00, 1'b0, 17,  0,  1, 1, 1'b0, 8'h00, 1'b1);
    vecs[1]  = mk(I2C_WRITE, 8'hA0, 1'b0, 145, 9,  0, 0, 1'b0, 8'h00, 1'b1);
    vecs[2]  = mk(I2C_WRITE, 8'h5A, 1'b0, 145, 9,  0, 0, 1'b0, 8'h00, 1'b1);
    vecs[3]  = mk(I2C_STOP,  8'h00, 1'b0, 17,  1,  1, 0, 1'b0, 8'h00, 1'b0);
    vecs[4]  = mk(I2C_START, 8'h00, 1'b0, 17,  0,  1, 1, 1'b0, 8'h00, 1'b1);
    vecs[5]  = mk(I2C_WRITE, 8'hA1, 1'b0, 145, 9,  0, 0, 1'b0, 8'h00, 1'b1);
    vecs[6]  = mk(I2C_READ,  8'h00, 1'b1, 145, 9,  0, 0, 1'b0, 8'hC3, 1'b1);
    vecs[7]  = mk(I2C_STOP,  8'h00, 1'b0, 17,  1,  1, 0, 1'b0, 8'hC3, 1'b0);
    vecs[8]  = mk(I2C_START, 8'h00, 1'b0, 17,  0,  1, 1, 1'b0, 8'hC3, 1'b1);
    vecs[9]  = mk(I2C_WRITE, 8'h84, 1'b0, 145, 9,  0, 0, 1'b1, 8'hC3, 1'b1);
    vecs[10] = mk(I2C_STOP,  8'h00, 1'b0, 17,  1,  1, 0, 1'b1, 8'hC3, 1'b0);
    vecs[11] = mk(I2C_WRITE, 8'hFF, 1'b0, -1,  0,  0, 0, 1'b1, 8'hC3, 1'b0);
    vecs[12] = mk(I2C_READ,  8'h00, 1'b0, -1,  0,  0, 0, 1'b1, 8'hC3, 1'b0);
    vecs[13] = mk(I2C_STOP,  8'h00, 1'b0, -1,  0,  0, 0, 1'b1, 8'hC3, 1'b0);
    vecs[14] = mk(I2C_START, 8'h00, 1'b0, 17,  0,  1, 1, 1'b1, 8'hC3, 1'b1);
    vecs[15] = mk(I2C_START, 8'h00, 1'b0, 17,  1,  1, 1, 1'b1, 8'hC3, 1'b1);
    vecs[16] = mk(I2C_STOP,  8'h00, 1'b0, 17,  1,  1, 0, 1'b1, 8'hC3, 1'b0);

    for (int i = 0; i < 17; i++) begin
      apply(vecs[i], $sformatf("v%0d", i));
      if (i == 3) chk("slave recv_data", slv_recv, 8'h5A);
      if (i == 7) chk("slave idle after read", s_active, 0);
    end

    // Reset in the middle of a WRITE, during bit 3 quarter 2
    apply(mk(I2C_START, 8'h00, 1'b0, 17, 0, 1, 1, 1'b1, 8'hC3, 1'b1), "pre_rst_start");
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd = I2C_WRITE; tx_data = 8'hA0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (58) @(posedge clk);
    #1;
    chk("mid_write scl_high", scl, 1);
    chk("mid_write busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort scl", scl, 1);
    chk("abort sda", sda_bus, 1);
    chk("abort cmd_ready", cmd_ready, 1);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    $display("cmd reset_abort scl=%0b sda=%0b busy=%0b", scl, sda_bus, busy);
    reset = 1'b0;
    apply(mk(I2C_START, 8'h00, 1'b0, 17,  0, 1, 1, 1'b0, 8'h00, 1'b1), "post_rst_start");
    apply(mk(I2C_WRITE, 8'hA0, 1'b0, 145, 9, 0, 0, 1'b0, 8'h00, 1'b1), "post_rst_write");
    apply(mk(I2C_STOP,  8'h00, 1'b0, 17,  1, 1, 0, 1'b0, 8'h00, 1'b0), "post_rst_stop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
